fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register. It sits directly upstream of the decode/control block. It keeps the PC, issues single-outstanding requests to instruction memory, and handles redirects from branch resolution (B/J/JR). It presents a registered instruction and PC to decode, and holds them under a decode stall. Bubbles and flushes are presented as the all-zero instruction, whose opcode 7'h00 decodes as NOP.

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose     : instruction fetch stage plus IF/ID pipeline register feeding decode.
// Latency     : one cycle from an accepted imem response to IF/ID; one per cycle with zero-wait memory.
// Backpressure: stall_i holds IF/ID; one extra response parks in a single-entry skid and fetch pauses.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   imem_req_o/addr_o    single-outstanding fetch request; address held stable until imem_valid_i
//   imem_valid_i/rdata_i response, may arrive in the request cycle or any later cycle
//   redirect_i/pc_i      taken branch/jump from execute; flushes IF/ID and the skid
//   stall_i              hazard-unit hold of IF/ID
//   if_id_valid_o/instr_o/pc_o  registered instruction to decode (instr is 0, a NOP, when not valid)
//
// Optional build macro FETCH_PERF_EN adds saturating counters fetch_cnt_o and bubble_cnt_o.

module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_valid_i,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    input  logic                stall_i,
    output logic                if_id_valid_o,
    output logic [INSTR_W-1:0]  if_id_instr_o,
    output logic [ADDR_W-1:0]   if_id_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_cnt_o,
    output logic [31:0]         bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_STALL = 2'd2,
        DISCARD    = 2'd3
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    hold_addr_q;   // address of the wrong-path request still in flight
    logic [INSTR_W-1:0]   skid_instr_q;
    logic [ADDR_W-1:0]    skid_pc_q;
    logic                 if_id_valid_q;
    logic [INSTR_W-1:0]   if_id_instr_q;
    logic [ADDR_W-1:0]    if_id_pc_q;

    logic [ADDR_W-1:0]    redirect_tgt;
    logic                 if_id_free;
    logic                 unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    // A stalled but empty IF/ID can still accept an instruction.
    assign if_id_free           = !if_id_valid_q || !stall_i;

    assign imem_req_o    = (state_q == REQ) || (state_q == DISCARD);
    assign imem_addr_o   = (state_q == DISCARD) ? hold_addr_q : pc_q;
    assign if_id_valid_o = if_id_valid_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc_o    = if_id_pc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            hold_addr_q   <= '0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                end

                REQ: begin
                    if (redirect_i) begin
                        // Any response landing this cycle is wrong-path and dropped. If the
                        // request is still open, wait it out at the old address.
                        pc_q          <= redirect_tgt;
                        hold_addr_q   <= pc_q;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= '0;
                        if_id_pc_q    <= '0;
                        skid_instr_q  <= '0;
                        skid_pc_q     <= '0;
                        state_q       <= imem_valid_i ? REQ : DISCARD;
                    end else if (imem_valid_i && if_id_free) begin
                        if_id_valid_q <= 1'b1;
                        if_id_instr_q <= imem_rdata_i;
                        if_id_pc_q    <= pc_q;
                        pc_q          <= pc_q + ADDR_W'(4);
                    end else if (imem_valid_i) begin
                        // IF/ID is held: park the response and stop requesting.
                        skid_instr_q  <= imem_rdata_i;
                        skid_pc_q     <= pc_q;
                        pc_q          <= pc_q + ADDR_W'(4);
                        state_q       <= WAIT_STALL;
                    end else if (!stall_i) begin
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= '0;
                    end
                end

                WAIT_STALL: begin
                    if (redirect_i) begin
                        pc_q          <= redirect_tgt;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= '0;
                        if_id_pc_q    <= '0;
                        skid_instr_q  <= '0;
                        skid_pc_q     <= '0;
                        state_q       <= REQ;
                    end else if (!stall_i) begin
                        if_id_valid_q <= 1'b1;
                        if_id_instr_q <= skid_instr_q;
                        if_id_pc_q    <= skid_pc_q;
                        skid_instr_q  <= '0;
                        skid_pc_q     <= '0;
                        state_q       <= REQ;
                    end
                end

                DISCARD: begin
                    // IF/ID was already flushed on entry; only the target can change here.
                    if (redirect_i) begin
                        pc_q <= redirect_tgt;
                    end
                    if (imem_valid_i) begin
                        state_q <= REQ;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_write;

    always_comb begin
        fetch_write = 1'b0;
        if (state_q == REQ && !redirect_i && imem_valid_i && if_id_free) begin
            fetch_write = 1'b1;
        end
        if (state_q == WAIT_STALL && !redirect_i && !stall_i) begin
            fetch_write = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (fetch_write && (fetch_cnt_o != 32'hFFFF_FFFF)) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (!if_id_valid_q && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose     : self-checking bench for fetch_stage (directed table, corner sequences, random run).
// Latency     : memory model answers after a configurable or random number of wait cycles.
// Backpressure: stall_i and redirect_i are driven from tables or at random.

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_valid_i  (imem_valid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .if_id_valid_o (if_id_valid),
        .if_id_instr_o (if_id_instr),
        .if_id_pc_o    (if_id_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .bubble_cnt_o  (bubble_cnt)
`endif
    );

    // Instruction memory: answers once a request has been open for `wait` extra cycles.
    int unsigned fixed_wait = 0;
    bit          rand_lat   = 1'b0;
    int unsigned cur_wait;
    int unsigned mem_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0200_0000 | a;
    endfunction

    assign imem_valid = imem_req && (mem_cnt >= (rand_lat ? cur_wait : fixed_wait));
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt  <= 0;
            cur_wait <= 0;
        end else if (imem_req && imem_valid) begin
            mem_cnt  <= 0;
            cur_wait <= $urandom_range(0, 3);
        end else if (imem_req) begin
            mem_cnt  <= mem_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc);
        check32({tag, " req"},   32'(imem_req),    32'(req));
        check32({tag, " addr"},  imem_addr,        addr);
        check32({tag, " valid"}, 32'(if_id_valid), 32'(v));
        check32({tag, " pc"},    if_id_pc,         pc);
        check32({tag, " instr"}, if_id_instr,      v ? mem_word(pc) : 32'h0);
    endtask

    // Reset is released right after a falling edge; the next falling edge sees the first REQ cycle.
    task automatic do_reset();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        rst_n       = 1'b1;
        #1;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] exp_pc;
        logic        prev_req, prev_ivalid, prev_hold;
        logic [31:0] prev_addr, prev_pc, prev_instr;
        int          consumed;

        // Zero-wait memory: streaming, a 4-cycle stall with skid, and redirects.
        // Inputs apply to this cycle; expected outputs are those visible during it.
        tbl[0]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h004, 1'b1, 32'h000};
        tbl[2]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h008, 1'b1, 32'h004};
        tbl[3]  = '{1'b1, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b1, 32'h008};
        tbl[4]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[5]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[6]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[7]  = '{1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[8]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h010, 1'b1, 32'h00C};
        tbl[9]  = '{1'b1, 1'b1, 32'h103, 1'b1, 32'h014, 1'b1, 32'h010};
        tbl[10] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100, 1'b0, 32'h000};
        tbl[11] = '{1'b0, 1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h100};
        tbl[12] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h200, 1'b0, 32'h000};
        tbl[13] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h204, 1'b1, 32'h200};

        fixed_wait = 0;
        rand_lat   = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            stall       = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            #1;
            check_outs($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc);
        end
        stall    = 1'b0;
        redirect = 1'b0;

        // Three-cycle memory: one instruction per three cycles, NOP bubbles between,
        // then a redirect to 0x103 while the request to 0x10 is still open.
        fixed_wait = 2;
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            logic [31:0] e_addr, e_pc;
            logic        e_v;
            @(negedge clk);
            redirect    = (k == 13);
            redirect_pc = (k == 13) ? 32'h103 : 32'h0;
            #1;
            if (k < 12) begin
                e_addr = 32'(4 * (k / 3));
                e_v    = (k >= 3) && (k % 3 == 0);
                e_pc   = 32'(4 * (k / 3 - 1));
            end else begin
                e_addr = (k <= 14) ? 32'h10 : ((k <= 17) ? 32'h100 : 32'h104);
                e_v    = (k == 12) || (k == 18);
                e_pc   = (k == 12) ? 32'hC : 32'h100;
            end
            check32($sformatf("lat3 k%0d req", k),   32'(imem_req),    32'h1);
            check32($sformatf("lat3 k%0d addr", k),  imem_addr,        e_addr);
            check32($sformatf("lat3 k%0d valid", k), 32'(if_id_valid), 32'(e_v));
            check32($sformatf("lat3 k%0d instr", k), if_id_instr,      e_v ? mem_word(e_pc) : 32'h0);
            if (e_v) check32($sformatf("lat3 k%0d pc", k), if_id_pc, e_pc);
        end
        redirect = 1'b0;

        // PC wrap from 0xFFFFFFFC, then reset asserted in the middle of a request.
        fixed_wait = 0;
        do_reset();
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check_outs("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check_outs("wrap1", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check_outs("wrap2", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
        @(negedge clk);
        fixed_wait = 3;
        #1;
        check_outs("midreq", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random run against a program-order model: every instruction decode accepts
        // must be the next sequential PC, restarting at each redirect target.
        rand_lat = 1'b1;
        do_reset();
        exp_pc      = 32'h0;
        consumed    = 0;
        prev_req    = 1'b0;
        prev_ivalid = 1'b0;
        prev_hold   = 1'b0;
        prev_addr   = '0;
        prev_pc     = '0;
        prev_instr  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = (cyc > 2) && ($urandom_range(0, 99) < 5);
            redirect_pc = $urandom;
            #1;
            check32("rnd addr align", 32'(imem_addr[1:0]), 32'h0);
            if (!if_id_valid) check32("rnd nop when invalid", if_id_instr, 32'h0);
            if (prev_req && !prev_ivalid && imem_req)
                check32("rnd addr stable", imem_addr, prev_addr);
            if (prev_hold) begin
                check32("rnd stall hold pc", if_id_pc, prev_pc);
                check32("rnd stall hold instr", if_id_instr, prev_instr);
            end
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (if_id_valid && !stall) begin
                check32("rnd order pc", if_id_pc, exp_pc);
                check32("rnd order instr", if_id_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_req    = imem_req;
            prev_ivalid = imem_valid;
            prev_addr   = imem_addr;
            prev_hold   = if_id_valid && stall && !redirect;
            prev_pc     = if_id_pc;
            prev_instr  = if_id_instr;
        end
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL rnd progress actual=%0d required>=%0d", consumed, 200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
